sram_march_bist: RTL

- March C- built-in self-test engine, directly upstream of one SRAM macro port 0 (1rw).
- Drives csb/web/wmask/addr/din into the macro in place of the control logic, selected by an external mux.
- Compares the registered read data returning from the macro's data-hold register against expected values.
- Reports pass/fail, the first failing address and data, and a failure count. Usable with every macro depth via a runtime address bound.

---
 rtl/sram_march_bist_if.sv | 46 ++++
 rtl/sram_march_bist.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist_if.sv
// ---------------------------------------------------------------------------
// sram_march_bist_if
// Single-port (1rw) SRAM macro bus as seen by the March BIST engine.
//
// Signals:
//   csb    chip select, active low          (master -> slave)
//   web    write enable, active low         (master -> slave)
//   wmask  per-byte write mask              (master -> slave)
//   addr   word address                     (master -> slave)
//   din    write data                       (master -> slave)
//   dout   registered read data (hold reg)  (slave  -> master)
//
// Modports:
//   master  BIST engine side
//   slave   SRAM macro side
// ---------------------------------------------------------------------------
interface sram_march_bist_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
);
  logic                   csb;
  logic                   web;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  modport master (
    output csb,
    output web,
    output wmask,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  csb,
    input  web,
    input  wmask,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/sram_march_bist.sv
// ---------------------------------------------------------------------------
// sram_march_bist
// March C- built-in self-test engine for one SRAM macro port (1rw).
//
// Elements (0 = bg_pattern, 1 = ~bg_pattern):
//   M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 | M5 up r0
// One SRAM op per cycle with no gaps. Each read pushes {valid, addr, expected}
// into a READ_LAT-deep pipeline; the compare happens when the registered read
// data returns. After the final read the engine drains READ_LAT cycles, then
// pulses done.
//
// Ports:
//   clk          test clock (same as SRAM)
//   resetn       asynchronous active-low reset
//   start        one-cycle pulse, launches a run when idle
//   addr_max     highest address tested (sampled at start)
//   bg_pattern   background data for "0" (sampled at start)
//   busy         high from the cycle after start until done
//   done         one-cycle pulse at run end
//   fail         sticky miscompare flag, cleared at start
//   fail_addr    address of first miscompare
//   fail_data    read data captured at first miscompare
//   fail_count   miscompare count, saturating at 255
//   sram         SRAM bus (master modport): csb/web/wmask/addr/din out, dout in
//
// Optional feature (macro MARCH_STOP_ON_FAIL_EN):
//   defined   - first miscompare stops issuing ops and goes straight to DRAIN;
//               reads already in flight are still compared and counted.
//   undefined - the full March runs regardless of failures.
// ---------------------------------------------------------------------------
module sram_march_bist #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int READ_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_max,
  input  logic [DATA_WIDTH-1:0] bg_pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            fail_count,
  sram_march_bist_if.master     sram
);

  localparam int DCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp;
  } cmp_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_n;
  logic                  phase, phase_n;    // 0: read slot, 1: write slot of a pair
  logic [DCW-1:0]        drain_cnt, drain_n;

  logic [ADDR_WIDTH-1:0] addr_max_q;
  logic [DATA_WIDTH-1:0] bg_q;
  cmp_t                  pipe [READ_LAT];

  logic                  is_rd, is_wr, descending, last_op, at_end;
  logic [DATA_WIDTH-1:0] rd_exp, wr_data;
  logic                  miscmp;
  logic                  launch;

  assign launch = (state == IDLE) && start;

  // ---------------------------------------------------------------------------
  // Op decode for the current March element
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_rd      = 1'b0;
    is_wr      = 1'b0;
    descending = 1'b0;
    last_op    = 1'b1;
    rd_exp     = bg_q;
    wr_data    = bg_q;
    case (state)
      M0: is_wr = 1'b1;
      M1, M2, M3, M4: begin
        is_rd   = !phase;
        is_wr   = phase;
        last_op = phase;
      end
      M5: is_rd = 1'b1;
      default: ;
    endcase
    descending = (state == M3) || (state == M4);
    // Reads of "1" happen in M2/M4; writes of "1" happen in M1/M3.
    if ((state == M2) || (state == M4)) rd_exp  = ~bg_q;
    if ((state == M1) || (state == M3)) wr_data = ~bg_q;
    at_end = descending ? (addr_cnt == '0) : (addr_cnt == addr_max_q);
  end

  assign sram.csb   = !(is_rd || is_wr);
  assign sram.web   = !is_wr;
  assign sram.wmask = is_wr ? '1 : '0;
  assign sram.addr  = (is_rd || is_wr) ? addr_cnt : '0;
  assign sram.din   = is_wr ? wr_data : '0;

  assign miscmp = pipe[READ_LAT-1].vld && (sram.dout != pipe[READ_LAT-1].exp);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // FSM: next state and address sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    addr_n  = addr_cnt;
    phase_n = phase;
    drain_n = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        if (!last_op) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (!at_end) begin
            addr_n = descending ? addr_cnt - ADDR_WIDTH'(1) : addr_cnt + ADDR_WIDTH'(1);
          end else begin
            // Element boundary: the only place the address counter wraps.
            case (state)
              M0:      state_n = M1;
              M1:      state_n = M2;
              M2:      state_n = M3;
              M3:      state_n = M4;
              M4:      state_n = M5;
              default: state_n = DRAIN;
            endcase
            addr_n  = ((state == M2) || (state == M3)) ? addr_max_q : '0;
            drain_n = '0;
          end
        end
`ifdef MARCH_STOP_ON_FAIL_EN
        // The op already on the bus this cycle completes; nothing after it.
        if (miscmp) begin
          state_n = DRAIN;
          drain_n = '0;
        end
`endif
      end
      DRAIN: begin
        if (drain_cnt == DCW'(READ_LAT - 1)) state_n = DONE;
        else                                 drain_n = drain_cnt + DCW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      addr_cnt  <= addr_n;
      phase     <= phase_n;
      drain_cnt <= drain_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Run configuration, compare pipeline and failure log
  // ---------------------------------------------------------------------------
  // NOTE: the compare pipeline is a handful of flops, not a RAM, so it is
  // fully reset; a stale valid bit after reset would log a false miscompare.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_max_q <= '0;
      bg_q       <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_count <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: is_rd, addr: addr_cnt, exp: rd_exp};
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];

      if (launch) begin
        addr_max_q <= addr_max;
        bg_q       <= bg_pattern;
        fail       <= 1'b0;
        fail_addr  <= '0;
        fail_data  <= '0;
        fail_count <= '0;
      end else if (miscmp) begin
        fail <= 1'b1;
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (!fail) begin
          fail_addr <= pipe[READ_LAT-1].addr;
          fail_data <= sram.dout;
        end
      end
    end
  end

endmodule
